// File: rtl/data_case_classifier_if.sv
// Stream bundle for data_case_classifier: upstream beat channel plus classified downstream channel.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; slave = classifier view, master = source/sink view.
interface data_case_classifier_if #(
    parameter int DSIZE = 8
);
    logic             in_valid;
    logic [DSIZE-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [DSIZE-1:0] out_data;
    logic [1:0]       out_class;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_class
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_class
    );
endinterface

// File: rtl/data_case_classifier.sv
// Tags each accepted beat with a 2-bit class (KEY0 -> 0, KEY1 -> 1, else 2) through a 2-entry skid buffer.
// Latency: beat accepted at edge N is presented from edge N onward (consumable in cycle N+1); 1 beat/cycle.
// Backpressure: in_ready is registered from buffer occupancy only; drops to 0 once two beats are held.
//
// Ports: clock, rst_n (async active-low); bus (slave modport: in_valid/in_data/in_ready,
// out_valid/out_data/out_class/out_ready); clr (sync counter clear); cnt0/cnt1/cnt2 (per-class
// delivered beats, saturating). Macro DATA_CASE_CLASSIFIER_CNT_EN enables the counters; when it
// is undefined the counters read 0 and clr is ignored.
module data_case_classifier #(
    parameter int               DSIZE = 8,
    parameter logic [DSIZE-1:0] KEY0  = DSIZE'(1),
    parameter logic [DSIZE-1:0] KEY1  = DSIZE'(2)
) (
    input  logic                   clock,
    input  logic                   rst_n,
    data_case_classifier_if.slave  bus,
    input  logic                   clr,
    output logic [15:0]            cnt0,
    output logic [15:0]            cnt1,
    output logic [15:0]            cnt2
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [DSIZE-1:0] e0_dat_q;
    logic [1:0]       e0_cls_q;
    logic [DSIZE-1:0] e1_dat_q;
    logic [1:0]       e1_cls_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [1:0]       in_cls_d;
    logic             in_hs;
    logic             out_hs;

    // KEY0 is tested first so it wins when both keys are equal.
    always_comb begin
        in_cls_d = 2'd2;
        if (bus.in_data == KEY0) begin
            in_cls_d = 2'd0;
        end else if (bus.in_data == KEY1) begin
            in_cls_d = 2'd1;
        end
    end

    assign in_hs  = bus.in_valid & in_ready_q;
    assign out_hs = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = e0_dat_q;
    assign bus.out_class = e0_cls_q;

    // Occupancy FSM; handshake flags are registered alongside the state so in_ready never
    // sees out_ready combinationally.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            e0_dat_q    <= '0;
            e0_cls_q    <= 2'd0;
            e1_dat_q    <= '0;
            e1_cls_q    <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        e0_dat_q    <= bus.in_data;
                        e0_cls_q    <= in_cls_d;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        // Head leaves while the new beat arrives: new beat becomes the head.
                        e0_dat_q <= bus.in_data;
                        e0_cls_q <= in_cls_d;
                    end else if (in_hs) begin
                        e1_dat_q   <= bus.in_data;
                        e1_cls_q   <= in_cls_d;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_hs) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_hs) begin
                        e0_dat_q   <= e1_dat_q;
                        e0_cls_q   <= e1_cls_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef DATA_CASE_CLASSIFIER_CNT_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;
    logic [15:0] cnt2_q;

    // Counts delivered beats by the class on the output; clr outranks a same-cycle increment.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 16'h0;
            cnt1_q <= 16'h0;
            cnt2_q <= 16'h0;
        end else if (clr) begin
            cnt0_q <= 16'h0;
            cnt1_q <= 16'h0;
            cnt2_q <= 16'h0;
        end else if (out_hs) begin
            case (e0_cls_q)
                2'd0: if (cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
                2'd1: if (cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
                2'd2: if (cnt2_q != 16'hFFFF) cnt2_q <= cnt2_q + 16'd1;
                default: ;
            endcase
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign cnt0 = 16'h0;
    assign cnt1 = 16'h0;
    assign cnt2 = 16'h0;
`endif

endmodule
